// File: rtl/thin_window_reader.sv
// thin_window_reader
// Streams an image from word-addressed memory and presents 3-row vertical
// windows (top/center/bottom words at the same column) for a thinning stage.
// Three line buffers are addressed through a mod-3 rotation pointer so that
// completed rows are never copied; the oldest row is overwritten in place.
module thin_window_reader #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_rows,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [31:0]       win_top,
  output logic [31:0]       win_center,
  output logic [31:0]       win_bottom,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int SUM_W = ADDR_W + 26;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WORDS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRIME  = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_EMIT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  // Word address of (row, col), wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0] b,
    input logic [15:0]       r,
    input logic [COL_W-1:0]  c
  );
    logic [SUM_W-1:0] s;
    s = SUM_W'(b) + SUM_W'(r) * SUM_W'(LINE_WORDS) + SUM_W'(c);
    return s[ADDR_W-1:0];
  endfunction

  // Next slot in the three-entry rotation.
  function automatic logic [1:0] mod3_inc(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] base_r;
  logic [15:0]       rows_r;
  logic [15:0]       row_r;
  logic [COL_W-1:0]  col_r;
  logic [1:0]        ptr_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       win_top_r;
  logic [31:0]       win_center_r;
  logic [31:0]       win_bottom_r;
  logic              win_valid_r;
  logic              busy_r;
  logic              done_r;

  logic [31:0]       line_buf_r [0:2][0:LINE_WORDS-1];

  logic              mem_done_s;
  logic              last_col_s;
  logic              last_row_s;
  logic [1:0]        top_slot_s;
  logic [1:0]        center_slot_s;
  logic [1:0]        bottom_slot_s;
  logic              buf_we_s;
  logic [1:0]        buf_slot_s;

  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign win_top    = win_top_r;
  assign win_center = win_center_r;
  assign win_bottom = win_bottom_r;
  assign win_valid  = win_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;

  // A read completes only while a request is actually outstanding.
  assign mem_done_s = mem_req_r & mem_rvalid;
  assign last_col_s = (col_r == LAST_COL);
  assign last_row_s = (row_r == (rows_r - 16'd1));

  // Map the rotation pointer onto the top/center/bottom buffer slots.
  always_comb begin
    top_slot_s    = ptr_r;
    center_slot_s = mod3_inc(ptr_r);
    bottom_slot_s = mod3_inc(mod3_inc(ptr_r));
  end

  // Decide which line buffer (if any) captures the returning read word.
  always_comb begin
    buf_we_s   = 1'b0;
    buf_slot_s = 2'd0;
    if ((state_r == ST_PRIME) && mem_done_s) begin
      buf_we_s   = 1'b1;
      buf_slot_s = row_r[0] ? 2'd1 : 2'd0;
    end else if ((state_r == ST_FETCH) && mem_done_s) begin
      buf_we_s   = 1'b1;
      buf_slot_s = bottom_slot_s;
    end else begin
      buf_we_s   = 1'b0;
      buf_slot_s = 2'd0;
    end
  end

  // Line buffer storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      line_buf_r[buf_slot_s][col_r] <= mem_rdata;
    end
  end

  // Pass sequencer with registered memory and window outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      base_r       <= {ADDR_W{1'b0}};
      rows_r       <= 16'd0;
      row_r        <= 16'd0;
      col_r        <= {COL_W{1'b0}};
      ptr_r        <= 2'd0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      win_top_r    <= 32'd0;
      win_center_r <= 32'd0;
      win_bottom_r <= 32'd0;
      win_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            base_r <= base_addr;
            rows_r <= num_rows;
            row_r  <= 16'd0;
            col_r  <= {COL_W{1'b0}};
            ptr_r  <= 2'd0;
            busy_r <= 1'b1;
            if (num_rows < 16'd3) begin
              // Too short to form any window: finish without touching memory.
              state_r <= ST_FINISH;
            end else begin
              state_r    <= ST_PRIME;
              mem_req_r  <= 1'b1;
              mem_addr_r <= base_addr;
            end
          end
        end

        ST_PRIME: begin
          if (mem_done_s) begin
            if (last_col_s) begin
              col_r <= {COL_W{1'b0}};
              if (row_r == 16'd1) begin
                row_r      <= 16'd2;
                state_r    <= ST_FETCH;
                mem_addr_r <= word_addr(base_r, 16'd2, {COL_W{1'b0}});
              end else begin
                row_r      <= 16'd1;
                mem_addr_r <= word_addr(base_r, 16'd1, {COL_W{1'b0}});
              end
            end else begin
              col_r      <= col_r + COL_W'(1);
              mem_addr_r <= word_addr(base_r, row_r, col_r + COL_W'(1));
            end
          end
        end

        ST_FETCH: begin
          if (mem_done_s) begin
            // The fresh word goes straight to the output; the buffer copy
            // serves the next two rows.
            mem_req_r    <= 1'b0;
            win_valid_r  <= 1'b1;
            win_top_r    <= line_buf_r[top_slot_s][col_r];
            win_center_r <= line_buf_r[center_slot_s][col_r];
            win_bottom_r <= mem_rdata;
            state_r      <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (win_ready) begin
            win_valid_r <= 1'b0;
            if (!last_col_s) begin
              col_r      <= col_r + COL_W'(1);
              state_r    <= ST_FETCH;
              mem_req_r  <= 1'b1;
              mem_addr_r <= word_addr(base_r, row_r, col_r + COL_W'(1));
            end else begin
              col_r <= {COL_W{1'b0}};
              ptr_r <= mod3_inc(ptr_r);
              if (last_row_s) begin
                state_r <= ST_FINISH;
              end else begin
                row_r      <= row_r + 16'd1;
                state_r    <= ST_FETCH;
                mem_req_r  <= 1'b1;
                mem_addr_r <= word_addr(base_r, row_r + 16'd1, {COL_W{1'b0}});
              end
            end
          end
        end

        ST_FINISH: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r     <= ST_IDLE;
          mem_req_r   <= 1'b0;
          win_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thin_window_reader.sv
// Testbench for thin_window_reader: table of frame passes plus randomized
// passes against an address-arithmetic reference model, and a mid-pass reset.
module tb_thin_window_reader;

  localparam int LW = 2;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   num_rows;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid;
  logic [31:0]   win_top, win_center, win_bottom;
  logic          win_valid;
  logic          win_ready;
  logic          busy, done;

  always #5 clk = ~clk;

  thin_window_reader #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .win_top(win_top),
    .win_center(win_center), .win_bottom(win_bottom), .win_valid(win_valid),
    .win_ready(win_ready), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model: data word = address ----------------
  int   lat_cnt  = 0;
  int   lat_tgt  = 0;
  bit   rand_lat = 1'b0;
  logic spur     = 1'b0;

  assign mem_rvalid = (mem_req && (lat_cnt >= lat_tgt)) || spur;
  assign mem_rdata  = mem_req ? {16'h0000, mem_addr} : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset) begin
      lat_cnt <= 0;
      lat_tgt <= 0;
    end else if (mem_req && mem_rvalid) begin
      lat_cnt <= 0;
      lat_tgt <= rand_lat ? int'($urandom_range(0, 5)) : 0;
    end else if (mem_req) begin
      lat_cnt <= lat_cnt + 1;
    end
  end

  // ---------------- window consumer ----------------
  int ready_mode = 0;   // 0: always ready, 1: three-cycle stall per window, 2: random
  int wait_left  = 3;

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: win_ready = 1'b1;
        1: begin
          if (!win_valid) begin
            win_ready = 1'b0;
            wait_left = 3;
          end else if (wait_left > 0) begin
            win_ready = 1'b0;
            wait_left--;
          end else begin
            win_ready = 1'b1;
          end
        end
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [95:0] obs_q[$];
  logic [15:0] addr_q[$];
  int          done_cnt = 0, done_cyc = 0, req_cycles = 0, valid_cycles = 0;
  bit          p_stall = 1'b0, p_req_wait = 1'b0, p_fetch_done = 1'b0;
  logic [95:0] p_win;
  logic [15:0] p_addr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [95:0] cur_win;
    bit cur_fetch;
    cur_win = {win_top, win_center, win_bottom};
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (reset) begin
      p_stall      = 1'b0;
      p_req_wait   = 1'b0;
      p_fetch_done = 1'b0;
    end else begin
      if (mem_req || win_valid)
        check("req_valid_exclusive", 96'(mem_req & win_valid), 96'd0);
      if (p_stall) begin
        check("stall_valid_held", 96'(win_valid), 96'd1);
        check("stall_data_held", cur_win, p_win);
      end
      if (p_req_wait)
        check("addr_held_while_req", 96'({mem_req, mem_addr}), 96'({1'b1, p_addr}));
      if (p_fetch_done)
        check("rvalid_to_win_valid", 96'(win_valid), 96'd1);
      if (mem_req) req_cycles++;
      if (win_valid) valid_cycles++;
      cur_fetch = mem_req && mem_rvalid && (addr_q.size() >= 2 * LW);
      if (mem_req && mem_rvalid) addr_q.push_back(mem_addr);
      if (win_valid && win_ready) obs_q.push_back(cur_win);
      p_stall      = win_valid && !win_ready;
      p_win        = cur_win;
      p_req_wait   = mem_req && !mem_rvalid;
      p_addr       = mem_addr;
      p_fetch_done = cur_fetch;
    end
  end

  // ---------------- stimulus records ----------------
  typedef struct {
    logic [15:0] base;
    logic [15:0] rows;
    bit          rlat;
    int          rmode;
    bit          mid_start;
    int          exp_windows;
  } vec_t;

  logic [95:0] req032 [4];
  logic [15:0] req035 [6];

  // Reference model: expected windows/addresses straight from row-major arithmetic.
  task automatic compare_model(input vec_t v);
    logic [95:0] ew[$];
    logic [15:0] ea[$];
    logic [15:0] a0, a1, a2;
    if (v.rows >= 16'd3) begin
      for (int i = 0; i < int'(v.rows) * LW; i++) ea.push_back(16'(int'(v.base) + i));
      for (int r = 2; r < int'(v.rows); r++) begin
        for (int c = 0; c < LW; c++) begin
          a0 = 16'(int'(v.base) + (r - 2) * LW + c);
          a1 = 16'(int'(v.base) + (r - 1) * LW + c);
          a2 = 16'(int'(v.base) + r * LW + c);
          ew.push_back({16'h0000, a0, 16'h0000, a1, 16'h0000, a2});
        end
      end
    end
    check("window_count", 96'(obs_q.size()), 96'(v.exp_windows));
    check("model_window_count", 96'(obs_q.size()), 96'(ew.size()));
    check("read_count", 96'(addr_q.size()), 96'(ea.size()));
    for (int i = 0; i < ew.size() && i < obs_q.size(); i++) check("window_data", obs_q[i], ew[i]);
    for (int i = 0; i < ea.size() && i < addr_q.size(); i++) check("read_addr", 96'(addr_q[i]), 96'(ea[i]));
  endtask

  task automatic check_req032();
    check("req032_count", 96'(obs_q.size()), 96'd4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) check("req032_window", obs_q[i], req032[i]);
  endtask

  task automatic run_pass(input vec_t v);
    int s;
    int k;
    rand_lat     = v.rlat;
    ready_mode   = v.rmode;
    obs_q.delete();
    addr_q.delete();
    done_cnt     = 0;
    req_cycles   = 0;
    valid_cycles = 0;
    @(posedge clk); #1;
    base_addr = v.base;
    num_rows  = v.rows;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
    check("busy_after_start", 96'(busy), 96'd1);
    if (v.rows >= 16'd3) check("first_req_latency", 96'(mem_req), 96'd1);
    k = 0;
    while (k < 3000 && done_cnt == 0) begin
      @(posedge clk); #1;
      if (v.mid_start && k == 6) begin
        start     = 1'b1;
        base_addr = 16'h5555;
        num_rows  = 16'd9;
      end else begin
        start = 1'b0;
      end
      k++;
    end
    start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 96'd0, 96'd1);
    if (v.rows < 16'd3) begin
      check("short_done_latency", 96'(done_cyc - s), 96'd1);
      check("short_no_req", 96'(req_cycles), 96'd0);
      check("short_no_valid", 96'(valid_cycles), 96'd0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 96'(done_cnt), 96'd1);
    check("idle_not_busy", 96'({busy, mem_req, win_valid}), 96'd0);
    compare_model(v);
  endtask

  vec_t tbl[8];

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   k;
    bit   found;

    req032[0] = {32'h100, 32'h102, 32'h104};
    req032[1] = {32'h101, 32'h103, 32'h105};
    req032[2] = {32'h102, 32'h104, 32'h106};
    req032[3] = {32'h103, 32'h105, 32'h107};
    req035[0] = 16'hFFFE; req035[1] = 16'hFFFF; req035[2] = 16'h0000;
    req035[3] = 16'h0001; req035[4] = 16'h0002; req035[5] = 16'h0003;

    //           base      rows    rlat  rmode mid  windows
    tbl[0] = '{16'h0100, 16'd4,  1'b0, 0, 1'b0, 4};
    tbl[1] = '{16'h0100, 16'd4,  1'b0, 1, 1'b0, 4};
    tbl[2] = '{16'h0100, 16'd2,  1'b0, 0, 1'b0, 0};
    tbl[3] = '{16'hFFFE, 16'd3,  1'b0, 0, 1'b0, 2};
    tbl[4] = '{16'h0100, 16'd4,  1'b1, 2, 1'b1, 4};
    tbl[5] = '{16'h0000, 16'd0,  1'b0, 0, 1'b0, 0};
    tbl[6] = '{16'h1234, 16'd1,  1'b0, 0, 1'b0, 0};
    tbl[7] = '{16'h0FF0, 16'd5,  1'b1, 1, 1'b0, 6};

    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 96'({mem_req, win_valid, busy, done}), 96'd0);
    check("reset_addr", 96'(mem_addr), 96'd0);
    check("reset_win", {win_top, win_center, win_bottom}, 96'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_pass(tbl[i]);
      if (i == 0 || i == 1 || i == 4) check_req032();
      if (i == 3) begin
        for (int j = 0; j < 6 && j < addr_q.size(); j++) check("req035_addr", 96'(addr_q[j]), 96'(req035[j]));
      end
    end

    for (int i = 0; i < 6; i++) begin
      v.base        = 16'($urandom);
      v.rows        = 16'($urandom_range(3, 7));
      v.rlat        = 1'b1;
      v.rmode       = int'($urandom_range(0, 2));
      v.mid_start   = 1'b0;
      v.exp_windows = (int'(v.rows) - 2) * LW;
      run_pass(v);
    end

    // Reset during the third window of the reference frame.
    ready_mode = 0;
    rand_lat   = 1'b0;
    obs_q.delete();
    addr_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    base_addr = 16'h0100;
    num_rows  = 16'd4;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    k = 0;
    while (k < 200 && !found) begin
      if (win_valid && obs_q.size() == 2) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
      k++;
    end
    check("third_emit_reached", 96'(found), 96'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_ctrl", 96'({mem_req, win_valid, busy, done}), 96'd0);
    check("midreset_addr", 96'(mem_addr), 96'd0);
    check("midreset_win", {win_top, win_center, win_bottom}, 96'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    spur  = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("spurious_rvalid_ignored", 96'({mem_req, win_valid, busy}), 96'd0);
    check("no_done_after_reset", 96'(done_cnt), 96'd0);
    check("windows_before_reset", 96'(obs_q.size()), 96'd2);
    run_pass(tbl[0]);
    check_req032();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thin_window_reader.md
THIN_WINDOW_READER -- requirements
Module: thin_window_reader

Interface
REQ-001 The block SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per image row (legal range 1..256).
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning memory word-address width.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  in  1  single-cycle request to begin a frame pass; sampled only in IDLE.
REQ-006 The block SHALL have port base_addr  in  ADDR_W  word address of row 0, word 0; captured on an accepted start.
REQ-007 The block SHALL have port num_rows  in  16  frame height in rows; captured on an accepted start.
REQ-008 The block SHALL have port mem_req  out  1  read request; held high with a stable mem_addr until mem_rvalid.
REQ-009 The block SHALL have port mem_addr  out  ADDR_W  word address being read.
REQ-010 The block SHALL have port mem_rdata  in  32  read data, valid when mem_rvalid is high.
REQ-011 The block SHALL have port mem_rvalid  in  1  read completion; ignored when mem_req is low.
REQ-012 The block SHALL have ports win_top, win_center, win_bottom  out  32 each  vertically aligned words for the thinning operation.
REQ-013 The block SHALL have ports win_valid out 1 and win_ready in 1  window handshake; transfer when both are high.
REQ-014 The block SHALL have ports busy out 1 (high outside IDLE) and done out 1 (one-cycle pulse at pass end).

Function
REQ-015 States SHALL be IDLE, PRIME, FETCH, EMIT, FINISH.
REQ-016 IDLE + start SHALL capture base_addr/num_rows, clear the row/column counters and go to PRIME; if num_rows < 3, go directly to FINISH instead.
REQ-017 PRIME SHALL read rows 0 and 1, all LINE_WORDS words each, into line buffers 0 and 1, one outstanding request at a time; after the last word of row 1, go to FETCH with row = 2, col = 0.
REQ-018 Address SHALL be (base_addr + row*LINE_WORDS + col) mod 2^ADDR_W.
REQ-019 FETCH SHALL request word (row, col); on mem_rvalid, write it into the buffer slot designated "bottom" and go to EMIT.
REQ-020 The line buffers SHALL rotate in order top <- center <- bottom by a mod-3 pointer advanced once per completed row, never by copying data.
REQ-021 EMIT SHALL assert win_valid with win_top = row-2, win_center = row-1, win_bottom = row, all at column col.
REQ-022 While win_valid && !win_ready, all three window outputs SHALL hold stable.
REQ-023 On transfer: if col < LINE_WORDS-1, col increments and the block returns to FETCH; otherwise col = 0 and the pointer rotates; if row = num_rows-1, the block goes to FINISH; otherwise row increments and the block returns to FETCH.
REQ-024 FINISH SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-025 A pass SHALL emit exactly (num_rows-2)*LINE_WORDS windows, in row-major order.
REQ-026 start outside IDLE SHALL be ignored; mem_rvalid with mem_req low SHALL be ignored.
REQ-027 Minimum latency SHALL be: first mem_req in the cycle after start; win_valid in the cycle after the mem_rvalid that completes FETCH.
REQ-028 mem_req and win_valid SHALL never be high in the same cycle.

Reset
REQ-029 While reset is high, the state SHALL be IDLE and mem_req, win_valid, busy and done SHALL be 0; mem_addr and the win_* data outputs SHALL be 0.
REQ-030 On reset, the counters and rotation pointer SHALL clear; line-buffer contents need not clear.
REQ-031 Reset asserted mid-pass SHALL abandon the pass without a done pulse, and any later mem_rvalid SHALL be ignored.

Verification
REQ-032 LINE_WORDS=2, base=0x0100, num_rows=4, memory word = address, zero-wait memory, win_ready=1 -> exactly 4 windows: (0x100,0x102,0x104), (0x101,0x103,0x105), (0x102,0x104,0x106), (0x103,0x105,0x107); done pulses once.
REQ-033 Same as REQ-032 with win_ready low for 3 cycles on each window -> identical sequence, and outputs stable during every stall.
REQ-034 num_rows=2 -> no mem_req and no win_valid; done pulses in the second cycle after start.
REQ-035 base=0xFFFE, LINE_WORDS=2, num_rows=3 -> read addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003.
REQ-036 mem_rvalid delayed a random 0..5 cycles, plus start pulsed mid-pass -> window sequence unchanged, the second start is ignored, and mem_addr is stable while mem_req is high.
REQ-037 Reset asserted during the third EMIT -> outputs are 0 in the next cycle with no done pulse; a fresh start then reproduces the REQ-032 sequence.
